// File: rtl/mixer_pkg.sv
// Shared constants, pipeline tag type and width helpers for the mixer_3 block.
// Optional clip detection in mixer_3 is enabled by defining MIXER_CLIP_DETECT_EN.
package mixer_pkg;

   localparam logic [7:0] ADR_LVL     = 8'h00;
   localparam logic [7:0] ADR_PAN     = 8'h01;
   localparam logic [7:0] ADR_MUTE    = 8'h40;
   localparam logic [7:0] ADR_MVOL    = 8'h7F;
   localparam logic [7:0] ADR_CLIPCLR = 8'h7E;

   localparam logic [7:0] RST_LVL_ON  = 8'h40;
   localparam logic [7:0] RST_LVL_OFF = 8'h00;
   localparam logic [7:0] RST_PAN     = 8'h40;
   localparam logic [7:0] RST_MUTE    = 8'h00;
   localparam logic [7:0] RST_MVOL    = 8'h40;
   localparam int unsigned RST_LVL_OSCS = 2;

   // Tag fields sized for the largest legal configuration (32 voices, 16 oscs).
   localparam int unsigned VX_MAX_W = 5;
   localparam int unsigned OX_MAX_W = 4;
   localparam int unsigned MUTE_MAX = 4;

   typedef struct packed {
      logic                valid;
      logic                last;
      logic [VX_MAX_W-1:0] vx;
      logic [OX_MAX_W-1:0] ox;
   } tag_t;

   function automatic int unsigned mul_w(input int unsigned a, input int unsigned b);
      return a + b;
   endfunction

   function automatic int unsigned mute_regs(input int unsigned voices);
      return (voices + 7) / 8;
   endfunction

endpackage

// File: rtl/mixer_sat.sv
// Arithmetic right shift followed by saturation to OUT_W signed bits.
// o_clip flags that the shifted value did not fit and was clamped.
module mixer_sat #(
   parameter int unsigned IN_W  = 72,
   parameter int unsigned SHIFT = 24,
   parameter int unsigned OUT_W = 24
) (
   input  logic signed [IN_W-1:0]  i_val,
   output logic signed [OUT_W-1:0] o_val,
   output logic                    o_clip
);

   logic signed [IN_W-1:0] w_sh;
   logic [IN_W-OUT_W:0]    w_hi;

   assign w_sh = i_val >>> SHIFT;
   // Value fits when every bit above the output sign bit matches it.
   assign w_hi   = w_sh[IN_W-1:OUT_W-1];
   assign o_clip = !((&w_hi) || (~|w_hi));

   always_comb begin
      if (!o_clip) begin
         o_val = w_sh[OUT_W-1:0];
      end else if (w_sh[IN_W-1]) begin
         o_val = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         o_val = {1'b0, {(OUT_W-1){1'b1}}};
      end
   end

endmodule

// File: rtl/mixer_3.sv
// Frame mixer: osc level, constant-sum pan, voice mute and master volume into saturated stereo.
// Define MIXER_CLIP_DETECT_EN to add sticky clip flags and a clipped-frame counter.
module mixer_3
   import mixer_pkg::*;
#(
   parameter int unsigned VOICES    = 8,
   parameter int unsigned V_OSC     = 4,
   parameter int unsigned V_WIDTH   = 3,
   parameter int unsigned O_WIDTH   = 2,
   parameter int unsigned SAMPLE_W  = 17,
   parameter int unsigned AUDIO_W   = 24,
   parameter int unsigned ACC_W     = 64,
   parameter int unsigned OUT_SHIFT = 21 + V_WIDTH / 2 + O_WIDTH
) (
   input  logic                       sCLK_XVXENVS,
   input  logic                       iRST,
   input  logic                       in_valid,
   input  logic                       in_last,
   input  logic [V_WIDTH-1:0]         in_vx,
   input  logic [O_WIDTH-1:0]         in_ox,
   input  logic signed [SAMPLE_W-1:0] in_sample,
   input  logic signed [7:0]          in_env,
   input  logic                       cfg_we,
   input  logic [7:0]                 cfg_adr,
   input  logic [7:0]                 cfg_wdata,
   output logic [7:0]                 cfg_rdata,
   output logic                       out_valid,
   output logic signed [AUDIO_W-1:0]  lsound_out,
`ifdef MIXER_CLIP_DETECT_EN
   output logic                       clip_l,
   output logic                       clip_r,
   output logic [15:0]                clip_cnt,
`endif
   output logic signed [AUDIO_W-1:0]  rsound_out
);

   localparam int unsigned P1_W   = mul_w(SAMPLE_W, 8);
   localparam int unsigned P2_W   = mul_w(P1_W, 8);
   localparam int unsigned P3_W   = mul_w(P2_W, 8);
   localparam int unsigned M_W    = mul_w(ACC_W, 8);
   localparam int unsigned N_MUTE = mute_regs(VOICES);

   logic [7:0] r_lvl  [V_OSC];
   logic [7:0] r_pan  [V_OSC];
   logic [7:0] r_mute [MUTE_MAX];
   logic [7:0] r_mvol;
   logic [7:0] r_rdata;
   logic [7:0] w_rdata;

   logic               w_osc_hit;
   logic               w_mute_hit;
   logic [O_WIDTH-1:0] w_osc;

   assign w_osc_hit  = (cfg_adr[7:6] == 2'b00) && ({28'd0, cfg_adr[5:2]} < V_OSC);
   assign w_mute_hit = (cfg_adr[7:6] == 2'b01) && ({26'd0, cfg_adr[5:0]} < N_MUTE);
   assign w_osc      = cfg_adr[2 +: O_WIDTH];

   always_comb begin
      w_rdata = 8'h00;
      if (w_osc_hit && cfg_adr[1:0] == ADR_LVL[1:0]) begin
         w_rdata = r_lvl[w_osc];
      end else if (w_osc_hit && cfg_adr[1:0] == ADR_PAN[1:0]) begin
         w_rdata = r_pan[w_osc];
      end else if (w_mute_hit) begin
         w_rdata = r_mute[cfg_adr[1:0]];
      end else if (cfg_adr == ADR_MVOL) begin
         w_rdata = r_mvol;
      end
   end

   always_ff @(posedge sCLK_XVXENVS) begin
      if (iRST) begin
         for (int o = 0; o < V_OSC; o++) begin
            r_lvl[o] <= (o < RST_LVL_OSCS) ? RST_LVL_ON : RST_LVL_OFF;
            r_pan[o] <= RST_PAN;
         end
         for (int k = 0; k < MUTE_MAX; k++) r_mute[k] <= RST_MUTE;
         r_mvol  <= RST_MVOL;
         r_rdata <= 8'h00;
      end else begin
         r_rdata <= w_rdata;
         if (cfg_we) begin
            if (w_osc_hit && cfg_adr[1:0] == ADR_LVL[1:0]) r_lvl[w_osc] <= cfg_wdata;
            if (w_osc_hit && cfg_adr[1:0] == ADR_PAN[1:0]) r_pan[w_osc] <= cfg_wdata;
            if (w_mute_hit) r_mute[cfg_adr[1:0]] <= cfg_wdata;
            if (cfg_adr == ADR_MVOL) r_mvol <= cfg_wdata;
         end
      end
   end

   assign cfg_rdata = r_rdata;

   tag_t                    r_s1, r_s2, r_s3;
   logic signed [P1_W-1:0]  r_p1;
   logic signed [P2_W-1:0]  r_p2;
   logic signed [P3_W-1:0]  r_pl, r_pr;
   logic signed [ACC_W-1:0] r_acc_l, r_acc_r;
   logic signed [M_W-1:0]   r_ml, r_mr;
   logic                    r_reload, r_s4_fire, r_s5_v;

   logic [31:0]        w_mute_flat;
   logic               w_muted;
   logic signed [7:0]  w_lvl, w_mvol, w_pan_l, w_pan_r;
   logic [7:0]         w_pan_raw;

   assign w_mute_flat = {r_mute[3], r_mute[2], r_mute[1], r_mute[0]};
   assign w_muted     = w_mute_flat[5'(in_vx)];
   assign w_lvl       = $signed(r_lvl[r_s1.ox[O_WIDTH-1:0]]);
   assign w_pan_raw   = r_pan[r_s2.ox[O_WIDTH-1:0]];
   // Pan is unsigned 0..127; register values with bit 7 set clamp to full right.
   assign w_pan_r     = w_pan_raw[7] ? 8'sd127 : $signed({1'b0, w_pan_raw[6:0]});
   assign w_pan_l     = 8'sd127 - w_pan_r;
   assign w_mvol      = $signed(r_mvol);

   logic signed [AUDIO_W-1:0] w_sat_l, w_sat_r;
   logic                      w_clip_l, w_clip_r;

   always_ff @(posedge sCLK_XVXENVS) begin
      if (iRST) begin
         r_s1       <= '0;
         r_s2       <= '0;
         r_s3       <= '0;
         r_p1       <= '0;
         r_p2       <= '0;
         r_pl       <= '0;
         r_pr       <= '0;
         r_acc_l    <= '0;
         r_acc_r    <= '0;
         r_reload   <= 1'b0;
         r_s4_fire  <= 1'b0;
         r_s5_v     <= 1'b0;
         r_ml       <= '0;
         r_mr       <= '0;
         out_valid  <= 1'b0;
         lsound_out <= '0;
         rsound_out <= '0;
      end else begin
         r_s1.valid <= in_valid;
         r_s1.last  <= in_valid & in_last;
         r_s1.vx    <= VX_MAX_W'(in_vx);
         r_s1.ox    <= OX_MAX_W'(in_ox);
         if (w_muted) r_p1 <= '0;
         else         r_p1 <= P1_W'(in_sample) * P1_W'(in_env);

         r_s2 <= r_s1;
         r_p2 <= P2_W'(r_p1) * P2_W'(w_lvl);

         r_s3 <= r_s2;
         r_pl <= P3_W'(r_p2) * P3_W'(w_pan_l);
         r_pr <= P3_W'(r_p2) * P3_W'(w_pan_r);

         // First entry after a frame end loads instead of adding, so frames can abut.
         if (r_s3.valid) begin
            r_acc_l  <= r_reload ? ACC_W'(r_pl) : r_acc_l + ACC_W'(r_pl);
            r_acc_r  <= r_reload ? ACC_W'(r_pr) : r_acc_r + ACC_W'(r_pr);
            r_reload <= r_s3.last;
         end
         r_s4_fire <= r_s3.valid & r_s3.last;

         r_s5_v <= r_s4_fire;
         if (r_s4_fire) begin
            r_ml <= M_W'(r_acc_l) * M_W'(w_mvol);
            r_mr <= M_W'(r_acc_r) * M_W'(w_mvol);
         end

         out_valid <= r_s5_v;
         if (r_s5_v) begin
            lsound_out <= w_sat_l;
            rsound_out <= w_sat_r;
         end
      end
   end

   mixer_sat #(
      .IN_W  (M_W),
      .SHIFT (OUT_SHIFT),
      .OUT_W (AUDIO_W)
   ) u_sat_l (
      .i_val  (r_ml),
      .o_val  (w_sat_l),
      .o_clip (w_clip_l)
   );

   mixer_sat #(
      .IN_W  (M_W),
      .SHIFT (OUT_SHIFT),
      .OUT_W (AUDIO_W)
   ) u_sat_r (
      .i_val  (r_mr),
      .o_val  (w_sat_r),
      .o_clip (w_clip_r)
   );

`ifdef MIXER_CLIP_DETECT_EN
   always_ff @(posedge sCLK_XVXENVS) begin
      if (iRST || (cfg_we && cfg_adr == ADR_CLIPCLR)) begin
         clip_l   <= 1'b0;
         clip_r   <= 1'b0;
         clip_cnt <= 16'h0000;
      end else if (r_s5_v) begin
         if (w_clip_l) clip_l <= 1'b1;
         if (w_clip_r) clip_r <= 1'b1;
         if ((w_clip_l || w_clip_r) && clip_cnt != 16'hFFFF) clip_cnt <= clip_cnt + 16'd1;
      end
   end
`endif

   // Tag fields past S1 and clip flags in the default build have no consumer.
   logic w_unused_tag;
   assign w_unused_tag = ^{r_s1, r_s2, r_s3, w_clip_l, w_clip_r};

endmodule

// File: tb/tb_mixer_3.sv
// Self-checking bench for mixer_3 against a frame-level arithmetic model.
// Clip checks are included when MIXER_CLIP_DETECT_EN is defined.
module tb_mixer_3;

   localparam int V_WIDTH   = 3;
   localparam int O_WIDTH   = 2;
   localparam int OUT_SHIFT = 21 + V_WIDTH / 2 + O_WIDTH;

   logic              clk;
   logic              iRST;
   logic              in_valid, in_last;
   logic [2:0]        in_vx;
   logic [1:0]        in_ox;
   logic signed [16:0] in_sample;
   logic signed [7:0] in_env;
   logic              cfg_we;
   logic [7:0]        cfg_adr, cfg_wdata, cfg_rdata;
   logic              out_valid;
   logic signed [23:0] lsound_out, rsound_out;
`ifdef MIXER_CLIP_DETECT_EN
   logic              clip_l, clip_r;
   logic [15:0]       clip_cnt;
`endif

   mixer_3 dut (
      .sCLK_XVXENVS (clk),
      .iRST         (iRST),
      .in_valid     (in_valid),
      .in_last      (in_last),
      .in_vx        (in_vx),
      .in_ox        (in_ox),
      .in_sample    (in_sample),
      .in_env       (in_env),
      .cfg_we       (cfg_we),
      .cfg_adr      (cfg_adr),
      .cfg_wdata    (cfg_wdata),
      .cfg_rdata    (cfg_rdata),
      .out_valid    (out_valid),
      .lsound_out   (lsound_out),
`ifdef MIXER_CLIP_DETECT_EN
      .clip_l       (clip_l),
      .clip_r       (clip_r),
      .clip_cnt     (clip_cnt),
`endif
      .rsound_out   (rsound_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model register file
   logic [7:0] m_lvl [4];
   logic [7:0] m_pan [4];
   logic [7:0] m_mute;
   logic [7:0] m_mvol;

   // Stimulus sequence (may hold several frames)
   int f_vx[$], f_ox[$], f_s[$], f_e[$];
   bit f_last[$];

   function automatic longint clamp24(input longint v);
      if (v > 64'sd8388607) return 64'sd8388607;
      if (v < -64'sd8388608) return -64'sd8388608;
      return v;
   endfunction

   function automatic void model_range(input int lo, input int hi,
                                       output longint l, output longint r);
      longint al, ar, base;
      int pn, lv, mv;
      al = 0;
      ar = 0;
      for (int i = lo; i <= hi; i++) begin
         if (m_mute[f_vx[i]] == 1'b0) begin
            pn = int'(m_pan[f_ox[i]]);
            if (pn > 127) pn = 127;
            lv = int'($signed(m_lvl[f_ox[i]]));
            base = longint'(f_s[i]) * longint'(f_e[i]) * longint'(lv);
            al += base * longint'(127 - pn);
            ar += base * longint'(pn);
         end
      end
      mv = int'($signed(m_mvol));
      l = clamp24((al * longint'(mv)) >>> OUT_SHIFT);
      r = clamp24((ar * longint'(mv)) >>> OUT_SHIFT);
   endfunction

   task automatic model_defaults();
      for (int o = 0; o < 4; o++) begin
         m_lvl[o] = (o < 2) ? 8'h40 : 8'h00;
         m_pan[o] = 8'h40;
      end
      m_mute = 8'h00;
      m_mvol = 8'h40;
   endtask

   task automatic do_reset();
      iRST = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      iRST = 1'b0;
      model_defaults();
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [7:0] d);
      cfg_we = 1'b1; cfg_adr = a; cfg_wdata = d;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      if (a[7:6] == 2'b00 && a[1:0] == 2'd0) m_lvl[a[3:2]] = d;
      if (a[7:6] == 2'b00 && a[1:0] == 2'd1) m_pan[a[3:2]] = d;
      if (a == 8'h40) m_mute = d;
      if (a == 8'h7F) m_mvol = d;
   endtask

   task automatic cfg_read(input logic [7:0] a, output logic [7:0] d);
      cfg_adr = a;
      @(posedge clk); #1;
      d = cfg_rdata;
   endtask

   task automatic clear_seq();
      f_vx.delete(); f_ox.delete(); f_s.delete(); f_e.delete(); f_last.delete();
   endtask

   task automatic push(input int vx, input int ox, input int s, input int e, input bit last);
      f_vx.push_back(vx); f_ox.push_back(ox); f_s.push_back(s); f_e.push_back(e);
      f_last.push_back(last);
   endtask

   task automatic send_seq(input int gap_pct);
      for (int i = 0; i < f_s.size(); i++) begin
         while (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) begin
            in_valid = 1'b0; in_last = 1'b0;
            @(posedge clk); #1;
         end
         in_valid  = 1'b1;
         in_last   = f_last[i];
         in_vx     = 3'(f_vx[i]);
         in_ox     = 2'(f_ox[i]);
         in_sample = 17'(f_s[i]);
         in_env    = 8'(f_e[i]);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Edges counted from the edge that captured the last sample; -1 if no strobe.
   task automatic wait_out(input int max_cyc, output int k,
                           output logic signed [23:0] l, output logic signed [23:0] r);
      k = 0; l = '0; r = '0;
      while (k < max_cyc) begin
         @(posedge clk); #1;
         k++;
         if (out_valid) begin
            l = lsound_out; r = rsound_out;
            return;
         end
      end
      k = -1;
   endtask

   task automatic check_frame(input string name, input int lo, input int hi,
                              input int k, input int k_exp,
                              input logic signed [23:0] l, input logic signed [23:0] r);
      longint el, er;
      logic signed [23:0] xl, xr;
      model_range(lo, hi, el, er);
      xl = 24'(el); xr = 24'(er);
      n_tests++;
      if (k !== k_exp) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d edges, want %0d", name, k, k_exp);
      end
      n_tests++;
      if (l !== xl) begin
         n_fail++;
         $display("FAIL %s_left: got %0d, want %0d", name, l, xl);
      end
      n_tests++;
      if (r !== xr) begin
         n_fail++;
         $display("FAIL %s_right: got %0d, want %0d", name, r, xr);
      end
   endtask

   task automatic test_reset();
      logic [7:0] ta [14] = '{8'h00, 8'h01, 8'h04, 8'h05, 8'h08, 8'h09, 8'h0C,
                              8'h0D, 8'h40, 8'h7F, 8'h02, 8'h41, 8'h7E, 8'h10};
      logic [7:0] te [14] = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h40, 8'h00,
                              8'h40, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
      logic [7:0] d;
      cfg_adr = 8'h00;
      do_reset();
      n_tests++;
      if (out_valid !== 1'b0 || lsound_out !== 24'sd0 || rsound_out !== 24'sd0
          || cfg_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b l=%0d r=%0d rd=%h, want 0 0 0 00",
                  out_valid, lsound_out, rsound_out, cfg_rdata);
      end
`ifdef MIXER_CLIP_DETECT_EN
      n_tests++;
      if (clip_l !== 1'b0 || clip_r !== 1'b0 || clip_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_clip: got %b %b %0d, want 0 0 0", clip_l, clip_r, clip_cnt);
      end
`endif
      cfg_write(8'h10, 8'h5A);
      for (int i = 0; i < 14; i++) begin
         cfg_read(ta[i], d);
         n_tests++;
         if (d !== te[i]) begin
            n_fail++;
            $display("FAIL reset_read[%h]: got %h, want %h", ta[i], d, te[i]);
         end
      end
   endtask

   task automatic test_single_osc();
      int k;
      logic signed [23:0] l, r;
      logic [7:0] pans [3] = '{8'h40, 8'h00, 8'h7F};
      do_reset();
      for (int p = 0; p < 3; p++) begin
         cfg_write(8'h01, pans[p]);
         clear_seq();
         push(0, 0, 16384, 127, 1'b1);
         send_seq(0);
         wait_out(20, k, l, r);
         check_frame($sformatf("single_pan%0d", pans[p]), 0, 0, k, 5, l, r);
         if (p == 0) begin
            n_tests++;
            if (l !== 24'sd32004 || r !== 24'sd32512) begin
               n_fail++;
               $display("FAIL single_abs: got %0d/%0d, want 32004/32512", l, r);
            end
         end
      end
   endtask

   task automatic test_saturation();
      int k;
      logic signed [23:0] l, r;
      int vals [2] = '{65535, -65536};
      logic signed [23:0] rexp [2] = '{24'sd8388607, -24'sd8388608};
      do_reset();
      for (int o = 0; o < 4; o++) begin
         cfg_write(8'(4 * o), 8'd127);
         cfg_write(8'(4 * o + 1), 8'd127);
      end
      cfg_write(8'h7F, 8'd127);
      for (int f = 0; f < 2; f++) begin
         clear_seq();
         for (int i = 0; i < 32; i++) push(i / 4, i % 4, vals[f], 127, i == 31);
         send_seq(0);
         wait_out(20, k, l, r);
         check_frame($sformatf("sat%0d", f), 0, 31, k, 5, l, r);
         n_tests++;
         if (r !== rexp[f]) begin
            n_fail++;
            $display("FAIL sat%0d_abs: got %0d, want %0d", f, r, rexp[f]);
         end
      end
`ifdef MIXER_CLIP_DETECT_EN
      n_tests++;
      if (clip_r !== 1'b1 || clip_l !== 1'b0 || clip_cnt !== 16'd2) begin
         n_fail++;
         $display("FAIL clip_state: got l=%b r=%b cnt=%0d, want 0 1 2", clip_l, clip_r, clip_cnt);
      end
      cfg_write(8'h7E, 8'h00);
      n_tests++;
      if (clip_r !== 1'b0 || clip_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL clip_clear: got r=%b cnt=%0d, want 0 0", clip_r, clip_cnt);
      end
`endif
   endtask

   task automatic test_mute();
      int k;
      logic signed [23:0] l, r;
      logic [7:0] d;
      do_reset();
      cfg_write(8'h40, 8'h08);
      cfg_read(8'h40, d);
      n_tests++;
      if (d !== 8'h08) begin
         n_fail++;
         $display("FAIL mute_read: got %h, want 08", d);
      end
      clear_seq();
      for (int o = 0; o < 4; o++) push(3, o, 30000, 100, 1'b0);
      push(5, 1, 0, 90, 1'b1);
      send_seq(0);
      wait_out(20, k, l, r);
      check_frame("mute_only", 0, 4, k, 5, l, r);
      n_tests++;
      if (l !== 24'sd0 || r !== 24'sd0) begin
         n_fail++;
         $display("FAIL mute_zero: got %0d/%0d, want 0/0", l, r);
      end
      clear_seq();
      push(3, 0, 30000, 100, 1'b0);
      push(1, 1, -20000, 120, 1'b1);
      send_seq(0);
      wait_out(20, k, l, r);
      check_frame("mute_mixed", 0, 1, k, 5, l, r);
   endtask

   task automatic test_back_to_back();
      int k1, k2;
      logic signed [23:0] l1, r1, l2, r2;
      do_reset();
      for (int o = 0; o < 4; o++) cfg_write(8'(4 * o), 8'd127);
      cfg_write(8'h7F, 8'd127);
      clear_seq();
      for (int i = 0; i < 4; i++) push(i, i, 1000, 127, i == 3);
      for (int i = 0; i < 4; i++) push(i + 4, i, 2000, 127, i == 3);
      send_seq(0);
      wait_out(20, k1, l1, r1);
      wait_out(20, k2, l2, r2);
      check_frame("b2b_first", 0, 3, k1, 1, l1, r1);
      check_frame("b2b_second", 4, 7, k2, 4, l2, r2);
   endtask

   task automatic test_reset_midframe();
      int k, strobes;
      logic signed [23:0] l, r;
      logic [7:0] d0, d1;
      do_reset();
      cfg_write(8'h00, 8'h20);
      cfg_write(8'h7F, 8'h10);
      clear_seq();
      for (int i = 0; i < 3; i++) push(i, 0, 5000, 100, i == 2);
      send_seq(0);
      iRST = 1'b1;
      @(posedge clk); #1;
      iRST = 1'b0;
      model_defaults();
      strobes = 0;
      for (int c = 0; c < 10; c++) begin
         if (out_valid) strobes++;
         @(posedge clk); #1;
      end
      n_tests++;
      if (strobes != 0) begin
         n_fail++;
         $display("FAIL abort_strobe: got %0d strobes, want 0", strobes);
      end
      cfg_read(8'h00, d0);
      cfg_read(8'h7F, d1);
      n_tests++;
      if (d0 !== 8'h40 || d1 !== 8'h40) begin
         n_fail++;
         $display("FAIL abort_regs: got lvl0=%h mvol=%h, want 40 40", d0, d1);
      end
      clear_seq();
      push(0, 0, 16384, 127, 1'b1);
      send_seq(0);
      wait_out(20, k, l, r);
      check_frame("abort_clean", 0, 0, k, 5, l, r);
   endtask

   task automatic test_random();
      int k, n;
      logic signed [23:0] l, r;
      logic [7:0] d;
      do_reset();
      for (int it = 0; it < 10; it++) begin
         for (int o = 0; o < 4; o++) begin
            cfg_write(8'(4 * o), 8'($urandom_range(255, 0)));
            cfg_write(8'(4 * o + 1), 8'($urandom_range(255, 0)));
         end
         cfg_write(8'h7F, 8'($urandom_range(255, 0)));
         cfg_write(8'h40, 8'($urandom_range(255, 0)));
         cfg_read(8'h05, d);
         n_tests++;
         if (d !== m_pan[1]) begin
            n_fail++;
            $display("FAIL rand%0d_readback: got %h, want %h", it, d, m_pan[1]);
         end
         clear_seq();
         n = int'($urandom_range(12, 1));
         for (int i = 0; i < n; i++)
            push(int'($urandom_range(7, 0)), int'($urandom_range(3, 0)),
                 int'($urandom_range(131071, 0)) - 65536,
                 int'($urandom_range(255, 0)) - 128, i == n - 1);
         send_seq(30);
         wait_out(20, k, l, r);
         check_frame($sformatf("rand%0d", it), 0, n - 1, k, 5, l, r);
      end
   endtask

   initial begin
      iRST = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_vx = '0; in_ox = '0;
      in_sample = '0; in_env = '0; cfg_we = 1'b0; cfg_adr = '0; cfg_wdata = '0;
      model_defaults();
      @(posedge clk); #1;
      test_reset();
      test_single_osc();
      test_saturation();
      test_mute();
      test_back_to_back();
      test_reset_midframe();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, want normal completion");
      $fatal(1, "watchdog");
   end

endmodule
